mux_2x1_arbiter: RTL and testbench

- Round-robin arbiter that shares one 2:1 mux output channel between two requesters.
- Owns the mux select line: grants the channel to requester 0 (data x1) or requester 1 (data x2) through a req/gnt handshake.
- Enforces a bounded hold time so neither requester can starve the other.
- Sits between two producer blocks and a single downstream consumer, on a single clock.

---
 rtl/mux_2x1_arbiter.sv | 102 ++++++++++
 tb/tb_mux_2x1_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter owning the select of a 2:1 mux shared by two requesters.
// Grants are registered; a hold counter forces handover so a contested owner cannot starve the peer.
module mux_2x1_arbiter #(
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic [1:0]   gnt,
    output logic         s,
    output logic [W-1:0] f,
    output logic         f_valid
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic       s_q, s_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                // On a tie the requester that was not served last wins.
                if (req == 2'b01 || (req == 2'b11 && last_q)) begin
                    state_d = StOwn0;
                    s_d     = 1'b0;
                    last_d  = 1'b0;
                end else if (req == 2'b10 || (req == 2'b11 && !last_q)) begin
                    state_d = StOwn1;
                    s_d     = 1'b1;
                    last_d  = 1'b1;
                end
            end
            StOwn0: begin
                if (!req[0] && !req[1]) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (req[1] && (!req[0] || cnt_q == HoldLast)) begin
                    state_d = StOwn1;
                    s_d     = 1'b1;
                    last_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else if (req[1] && cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StOwn1: begin
                if (!req[0] && !req[1]) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (req[0] && (!req[1] || cnt_q == HoldLast)) begin
                    state_d = StOwn0;
                    s_d     = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (req[0] && cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        gnt     = {state_q == StOwn1, state_q == StOwn0};
        s       = s_q;
        f       = s_q ? x2 : x1;
        f_valid = |gnt;
    end

    grant_onehot_a : assert property (@(posedge clk) gnt != 2'b11);

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: a turn-taking model checked every cycle
// plus literal expectations at the scenario milestones.
module tb_mux_2x1_arbiter;

    localparam int unsigned W        = 8;
    localparam int unsigned MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] x1, x2;
    logic [1:0]   gnt;
    logic         s;
    logic [W-1:0] f;
    logic         f_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mux_2x1_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .x1      (x1),
        .x2      (x2),
        .gnt     (gnt),
        .s       (s),
        .f       (f),
        .f_valid (f_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: who owns the channel, who was served last, and how many cycles
    // the current owner has kept it while the other side was waiting.
    int owner = -1;
    int last_m = 1;
    int waited = 0;
    int sel_m = 0;
    bit model_valid = 1'b0;

    function automatic void give(input int p);
        owner  = p;
        last_m = p;
        sel_m  = p;
        waited = 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            owner = -1; last_m = 1; waited = 0; sel_m = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (owner < 0) begin
                if (req == 2'b11)      give(1 - last_m);
                else if (req == 2'b01) give(0);
                else if (req == 2'b10) give(1);
            end else begin
                if (!req[owner]) begin
                    if (req[1 - owner]) give(1 - owner);
                    else begin owner = -1; waited = 0; end
                end else if (req[1 - owner]) begin
                    if (waited + 1 >= MAX_HOLD) give(1 - owner);
                    else waited++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_gnt", {30'd0, gnt},
                owner == 0 ? 32'd1 : (owner == 1 ? 32'd2 : 32'd0));
            chk("model_s", {31'd0, s}, sel_m);
            chk("model_f_valid", {31'd0, f_valid}, owner >= 0 ? 32'd1 : 32'd0);
            chk("model_f", {24'd0, f}, {24'd0, (sel_m == 1) ? x2 : x1});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b11;
        x1    = 8'hA5;
        x2    = 8'h3C;
        tick(2);
        chk("rst_gnt", {30'd0, gnt}, 32'h0);
        chk("rst_s", {31'd0, s}, 32'h0);
        chk("rst_f_valid", {31'd0, f_valid}, 32'h0);

        reset = 1'b0;
        tick(1);
        chk("rel_gnt", {30'd0, gnt}, 32'h1);
        chk("rel_s", {31'd0, s}, 32'h0);
        chk("rel_f", {24'd0, f}, 32'hA5);

        req = 2'b00;
        tick(1);
        chk("drop_gnt", {30'd0, gnt}, 32'h0);

        // Single requester 1.
        req = 2'b10;
        tick(1);
        chk("single_gnt", {30'd0, gnt}, 32'h2);
        chk("single_s", {31'd0, s}, 32'h1);
        chk("single_f", {24'd0, f}, 32'h3C);
        tick(4);
        chk("single_hold", {30'd0, gnt}, 32'h2);
        req = 2'b00;
        tick(1);
        chk("single_end_gnt", {30'd0, gnt}, 32'h0);
        chk("single_end_s", {31'd0, s}, 32'h1);

        // Serve requester 0 briefly, then a tie must go to requester 1.
        req = 2'b01;
        tick(1);
        chk("serve0_gnt", {30'd0, gnt}, 32'h1);
        req = 2'b00;
        tick(1);
        req = 2'b11;
        tick(1);
        chk("tie_gnt", {30'd0, gnt}, 32'h2);
        tick(2);
        chk("tie_hold", {30'd0, gnt}, 32'h2);
        req = 2'b01;
        tick(1);
        chk("direct_handover", {30'd0, gnt}, 32'h1);
        chk("direct_s", {31'd0, s}, 32'h0);

        // Both requesting: 8 cycles each, alternating, never idle or 11.
        req = 2'b11;
        x1  = 8'h5A;
        for (int i = 1; i < 32; i++) begin
            tick(1);
            chk("forced_alt", {30'd0, gnt}, ((i / 8) % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Uncontested owner keeps the channel; contention pre-empts after 8 cycles.
        req = 2'b01;
        tick(40);
        chk("uncontested", {30'd0, gnt}, 32'h1);
        req = 2'b11;
        tick(7);
        chk("contest_7", {30'd0, gnt}, 32'h1);
        tick(1);
        chk("contest_8", {30'd0, gnt}, 32'h2);

        // Reset mid-grant with the counter at 5.
        tick(5);
        chk("pre_reset_gnt", {30'd0, gnt}, 32'h2);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_gnt", {30'd0, gnt}, 32'h0);
        chk("mid_rst_s", {31'd0, s}, 32'h0);
        reset = 1'b0;
        tick(1);
        chk("post_rst_gnt", {30'd0, gnt}, 32'h1);

        req = 2'b00;
        tick(3);
        chk("final_idle", {30'd0, gnt}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
